tk1_round_ctrl: RTL and testbench
=================================

# tk1_round_ctrl

Round sequencer for the TK1 (public counter) lane of the SKINNY-128-384+ tweakey schedule used by the Romulus mode. It holds the 56-bit block-counter LFSR and assembles TK1 from that counter and a domain-separation byte when a TBC call starts. It then steps the TK1 byte permutation once per round, one round per non-stalled cycle, and provides the 64-bit TK1 round-key slice, the round index and start/done handshakes to the masked cipher core. TK1 is public, so the lane is unshared.

## Interface
- ROUNDS, 40, number of TBC rounds per call (≥ 2, ≤ 63)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cnt_init  in  1  load counter LFSR with 56'h1
- cnt_inc  in  1  advance counter LFSR one step
- dom  in  8  domain-separation byte, sampled on accepted start
- start  in  1  request a TBC call; accepted only when busy=0
- stall  in  1  core not ready; freezes round progress
- busy  out  1  call in progress
- done  out  1  one-cycle pulse after last round consumed
- rk_valid  out  1  rk1/round valid for the core
- round  out  6  current round index, 0..ROUNDS-1
- last  out  1  round == ROUNDS-1 while rk_valid
- rk1  out  64  TK1 rows 0–1 (tk1[127:64])
- cnt  out  56  current counter LFSR value

## Operation
- Byte i of 128-bit tk1 is bits [127-8i -: 8].
- Load on accepted start: bytes 0..6 = cnt[7:0], cnt[15:8], …, cnt[55:48]; byte 7 = dom; bytes 8..15 = 0.
- Per-round permutation PT: new bytes 0..7 = old bytes 9,15,8,13,10,14,12,11; new bytes 8..15 = old bytes 0..7. PT has period 16.
- Counter LFSR (x^56+x^7+x^4+x^2+1): next = {cnt[54:0],1'b0} ^ (cnt[55] ? 56'h95 : 0). The value never reaches zero if it is nonzero at start. Period 2^56−1; wrap-around is implicit.
- cnt_init has priority over cnt_inc in the same cycle. Both are honoured in any state. They never affect a tk1 value that is already loaded.
- FSM states:
  - IDLE: busy=0, rk_valid=0. start → RUN, load tk1, round=0.
  - RUN: busy=1, rk_valid=1.
    - stall=1: hold tk1 and round.
    - stall=0 and round<ROUNDS-1: round+1, tk1 ← PT(tk1).
    - stall=0 and round=ROUNDS-1: → IDLE, done=1 next cycle, tk1 and round hold.
- start while busy=1 is ignored, with no queuing. This includes start in the same cycle as the last round's exit.
- start and cnt_inc in the same cycle: tk1 is loaded from the pre-increment counter.
- rst_n low at any time, including mid-call: immediate return to IDLE, with all outputs at reset values and the call discarded.

## Timing
- Reset values: busy=0, done=0, rk_valid=0, last=0, round=0, rk1=0, cnt=56'h1, tk1=0.
- start accepted at edge t: from t+1, rk_valid=1, round=0, rk1 = loaded rows.
- With no stall, round k is presented in cycle t+1+k. Last round is at t+ROUNDS. done=1 during cycle t+ROUNDS+1, and busy=0 in the same cycle.
- Each stall cycle adds exactly one cycle of latency. stall is ignored in IDLE.
- A new start is accepted in the cycle done is high, giving back-to-back calls with a one-cycle gap.
- All outputs are registered except last, which is decoded from round and state.

## Test plan
- Reset, then 56 cnt_inc pulses → cnt walks 1,2,4,…,2^55, then cnt = 56'h95 on the 56th. cnt_init together with cnt_inc → cnt = 56'h1.
- cnt=1, dom=8'h1A, start, no stall → round 0 rk1=64'h0100_0000_0000_001A, round 1 rk1=0, round 2 rk1=64'h001A_0100_0000_0000, round 16 rk1 equal to round 0.
- Same call → done pulses exactly at t+41. busy is high for cycles t+1..t+40. last is high only at round 39.
- stall held high for 3 cycles at round 5 → round stays 5 and rk1 is frozen. done is at t+44.
- start while busy, and start together with cnt_inc from cnt=56'h80 → first is ignored. Second loads byte 0 = 8'h80, and cnt becomes 56'h100.
- rst_n low at round 20 → busy, rk_valid and round go to 0 asynchronously and cnt=1. A subsequent start runs a full 40-round call.

Source files
------------

// File: rtl/tk1_round_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tk1_round_ctrl
// Purpose  : TK1 (public block-counter) lane sequencer for SKINNY-128-384+
//            as used by Romulus. Holds the 56-bit counter LFSR, builds TK1
//            from counter and domain byte on call start, then applies the
//            TK1 byte permutation once per non-stalled round.
// Revision : 1.0 - initial release
// ============================================================================
module tk1_round_ctrl #(
  parameter int ROUNDS = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cnt_init,
  input  logic        cnt_inc,
  input  logic [7:0]  dom,
  input  logic        start,
  input  logic        stall,
  output logic        busy,
  output logic        done,
  output logic        rk_valid,
  output logic [5:0]  round,
  output logic        last,
  output logic [63:0] rk1,
  output logic [55:0] cnt
);

  localparam logic [5:0]  LAST_ROUND = 6'(ROUNDS - 1);
  localparam logic [55:0] CNT_RESET  = 56'h1;
  localparam logic [55:0] CNT_TAPS   = 56'h95;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t       state;
  logic [127:0] tk1;

  // One step of the x^56+x^7+x^4+x^2+1 Galois LFSR.
  function automatic logic [55:0] lfsr_next(input logic [55:0] c);
    return {c[54:0], 1'b0} ^ (c[55] ? CNT_TAPS : 56'h0);
  endfunction

  // Counter bytes go low byte first into TK1 bytes 0..6, domain in byte 7,
  // second row pair is all zero.
  function automatic logic [127:0] load_tk1(input logic [55:0] c,
                                            input logic [7:0]  d);
    return {c[7:0], c[15:8], c[23:16], c[31:24], c[39:32], c[47:40],
            c[55:48], d, 64'h0};
  endfunction

  // Byte k of t lives at t[127-8k -: 8]; new bytes 0..7 are old bytes
  // 9,15,8,13,10,14,12,11 and the old upper half drops into bytes 8..15.
  function automatic logic [127:0] pt(input logic [127:0] t);
    return {t[55:48], t[7:0], t[63:56], t[23:16],
            t[47:40], t[15:8], t[31:24], t[39:32],
            t[127:64]};
  endfunction

  // Block counter: init wins over increment; independent of the call FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= CNT_RESET;
    end else if (cnt_init) begin
      cnt <= CNT_RESET;
    end else if (cnt_inc) begin
      cnt <= lfsr_next(cnt);
    end
  end

  // Call FSM: load TK1 on accepted start, step one round per free cycle,
  // pulse done for one cycle after the last round is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      done     <= 1'b0;
      round    <= 6'd0;
      tk1      <= 128'h0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            rk_valid <= 1'b1;
            round    <= 6'd0;
            tk1      <= load_tk1(cnt, dom);
          end
        end
        RUN: begin
          if (!stall) begin
            if (round == LAST_ROUND) begin
              // tk1 and round are left as they were for the final round.
              state    <= IDLE;
              busy     <= 1'b0;
              rk_valid <= 1'b0;
              done     <= 1'b1;
            end else begin
              round <= round + 6'd1;
              tk1   <= pt(tk1);
            end
          end
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          rk_valid <= 1'b0;
        end
      endcase
    end
  end

  assign last = rk_valid && (round == LAST_ROUND);
  assign rk1  = tk1[127:64];

endmodule
`default_nettype wire

// File: tb/tb_tk1_round_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_tk1_round_ctrl
// Purpose  : Directed self-checking bench for tk1_round_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tk1_round_ctrl;

  localparam int ROUNDS = 40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cnt_init, cnt_inc, start, stall;
  logic [7:0]  dom;
  logic        busy, done, rk_valid, last;
  logic [5:0]  round;
  logic [63:0] rk1;
  logic [55:0] cnt;

  int checks = 0;
  int errors = 0;
  logic [55:0] ecnt;
  logic [63:0] snap [4];

  tk1_round_ctrl #(.ROUNDS(ROUNDS)) dut (
    .clk(clk), .rst_n(rst_n), .cnt_init(cnt_init), .cnt_inc(cnt_inc),
    .dom(dom), .start(start), .stall(stall), .busy(busy), .done(done),
    .rk_valid(rk_valid), .round(round), .last(last), .rk1(rk1), .cnt(cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [55:0] lfsr(input logic [55:0] c);
    logic [55:0] n;
    n = c << 1;
    if (c[55]) n = n ^ 56'h95;
    return n;
  endfunction

  function automatic logic [127:0] load_model(input logic [55:0] c,
                                              input logic [7:0]  d);
    logic [127:0] t;
    t = '0;
    for (int i = 0; i < 7; i++) t[127-8*i -: 8] = c[8*i +: 8];
    t[127-8*7 -: 8] = d;
    return t;
  endfunction

  function automatic logic [127:0] pt_model(input logic [127:0] t);
    logic [7:0]   b [16];
    logic [7:0]   n [16];
    int           src [8];
    logic [127:0] r;
    src = '{9, 15, 8, 13, 10, 14, 12, 11};
    for (int i = 0; i < 16; i++) b[i] = t[127-8*i -: 8];
    for (int i = 0; i < 8; i++) begin
      n[i]   = b[src[i]];
      n[8+i] = b[i];
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = n[i];
    return r;
  endfunction

  // Issue a start in the current cycle and follow the call to its done
  // cycle (or abort with reset when round abort_at is reached).
  task automatic run_call(input logic [7:0] d, input int stall_at,
                          input int stall_len, input bit inc_with_start,
                          input bit poke_start, input int abort_at);
    logic [127:0] m;
    int er;
    int held;
    bit st;
    m = load_model(ecnt, d);
    dom = d; start = 1'b1; cnt_inc = inc_with_start;
    step;
    start = 1'b0; cnt_inc = 1'b0;
    if (inc_with_start) ecnt = lfsr(ecnt);
    check("cnt_after_start", 64'(cnt), 64'(ecnt));
    er = 0; held = 0;
    for (int cyc = 1; cyc <= ROUNDS + stall_len; cyc++) begin
      check("busy_run", 64'(busy), 64'd1);
      check("rk_valid_run", 64'(rk_valid), 64'd1);
      check("done_run", 64'(done), 64'd0);
      check("round", 64'(round), 64'(er));
      check("last", 64'(last), 64'(er == ROUNDS - 1));
      check("rk1", rk1, m[127:64]);
      if (held == 0 && er < 4) snap[er] = rk1;
      if (er == 16) snap[3] = rk1;
      if (er == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rk_valid", 64'(rk_valid), 64'd0);
        check("rst_round", 64'(round), 64'd0);
        check("rst_cnt", 64'(cnt), 64'h1);
        check("rst_rk1", rk1, 64'h0);
        check("rst_last", 64'(last), 64'd0);
        ecnt = 56'h1;
        #1 rst_n = 1'b1;
        @(negedge clk);
        return;
      end
      st = (er == stall_at) && (held < stall_len);
      stall = st;
      start = poke_start && (er == 3 || er == ROUNDS - 1);
      step;
      stall = 1'b0; start = 1'b0;
      if (st) held++;
      else if (er < ROUNDS - 1) begin
        er++;
        m = pt_model(m);
      end
    end
    check("done_pulse", 64'(done), 64'd1);
    check("busy_at_done", 64'(busy), 64'd0);
    check("rk_valid_at_done", 64'(rk_valid), 64'd0);
    check("last_at_done", 64'(last), 64'd0);
  endtask

  initial begin
    rst_n = 1'b1; cnt_init = 1'b0; cnt_inc = 1'b0; start = 1'b0;
    stall = 1'b0; dom = 8'h00; ecnt = 56'h1;
    #1 rst_n = 1'b0;
    #2;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_rk_valid", 64'(rk_valid), 64'd0);
    check("reset_last", 64'(last), 64'd0);
    check("reset_round", 64'(round), 64'd0);
    check("reset_rk1", rk1, 64'h0);
    check("reset_cnt", 64'(cnt), 64'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // Counter walk: 1,2,4,...,2^55 then the feedback taps 0x95.
    for (int i = 0; i < 56; i++) begin
      logic [55:0] exp_c;
      cnt_inc = 1'b1;
      step;
      exp_c = (i < 55) ? (56'h1 << (i + 1)) : 56'h95;
      check("cnt_walk", 64'(cnt), 64'(exp_c));
    end
    cnt_init = 1'b1;
    step;
    cnt_init = 1'b0; cnt_inc = 1'b0;
    check("cnt_init_priority", 64'(cnt), 64'h1);
    ecnt = 56'h1;

    // Stall while idle does nothing.
    stall = 1'b1;
    step;
    stall = 1'b0;
    check("idle_stall_busy", 64'(busy), 64'd0);
    check("idle_stall_rk_valid", 64'(rk_valid), 64'd0);

    // Plain call, then back-to-back call with a 3-cycle stall at round 5.
    run_call(8'h1A, -1, 0, 1'b0, 1'b0, -1);
    check("call1_r0", snap[0], 64'h0100_0000_0000_001A);
    check("call1_r1", snap[1], 64'h0);
    check("call1_r2", snap[2], 64'h001A_0100_0000_0000);
    check("call1_r16", snap[3], 64'h0100_0000_0000_001A);
    run_call(8'h1A, 5, 3, 1'b0, 1'b0, -1);
    step;
    check("idle_after_stall_call", 64'(busy), 64'd0);

    // Counter to 0x80, then start with cnt_inc; starts poked while busy.
    cnt_init = 1'b1;
    step;
    cnt_init = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cnt_inc = 1'b1;
      step;
    end
    cnt_inc = 1'b0;
    check("cnt_0x80", 64'(cnt), 64'h80);
    ecnt = 56'h80;
    run_call(8'h55, -1, 0, 1'b1, 1'b1, -1);
    check("cnt_after_inc_start", 64'(cnt), 64'h100);
    check("inc_start_r0", snap[0], 64'h8000_0000_0000_0055);
    step;
    check("no_queued_start", 64'(busy), 64'd0);

    // Reset mid-call at round 20, then a full call from a clean state.
    run_call(8'h1A, -1, 0, 1'b0, 1'b0, 20);
    run_call(8'h3C, -1, 0, 1'b0, 1'b0, -1);
    check("post_reset_r0", snap[0], 64'h0100_0000_0000_003C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
